// File: rtl/bod_pkg.sv
// ----------------------------------------------------------------------------
// bod_pkg
// Shared constants and types for the brown-out rate monitor.
//   DEFAULT_DATA_W : default width of ADC / supply / minimum codes
//   RATE_SHIFT     : the slew limit is the nominal-to-minimum span divided
//                    by 2**RATE_SHIFT
//   adc_code_t     : one ADC code at the default width
// Optional feature macro used by the importing files: BOD_HYST_EN
// ----------------------------------------------------------------------------
package bod_pkg;

    localparam int DEFAULT_DATA_W = 8;
    localparam int RATE_SHIFT     = 3;

    typedef logic [DEFAULT_DATA_W-1:0] adc_code_t;

endpackage : bod_pkg

// File: rtl/bod_comparator.sv
// ----------------------------------------------------------------------------
// bod_comparator
// Purely combinational threshold logic for the brown-out monitor.
// It derives the trip threshold and the slew limit from the two reference
// codes, then classifies the current ADC sample against the threshold.
// Ports:
//   i_adc        in   DATA_W  current ADC sample
//   i_supplyVol  in   DATA_W  nominal supply code
//   i_minVol     in   DATA_W  minimum allowed supply code
//   o_bodValue   out  DATA_W  trip threshold, midpoint of nominal and minimum
//   o_rateLimit  out  DATA_W  largest per-sample drop that is not a fast drop
//   o_below      out  1       sample strictly below the threshold
//   o_clearOk    out  1       sample high enough to release the alarms
// Macro BOD_HYST_EN: when defined, release needs the sample to reach
// threshold + HYST (saturating at full scale); otherwise release happens as
// soon as the sample is no longer below the threshold. HYST is unused when
// the macro is not defined.
// ----------------------------------------------------------------------------
module bod_comparator
    import bod_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int HYST   = 4
) (
    input  logic [DATA_W-1:0] i_adc,
    input  logic [DATA_W-1:0] i_supplyVol,
    input  logic [DATA_W-1:0] i_minVol,
    output logic [DATA_W-1:0] o_bodValue,
    output logic [DATA_W-1:0] o_rateLimit,
    output logic              o_below,
    output logic              o_clearOk
);

    logic [DATA_W:0]   w_refSum;
    logic [DATA_W-1:0] w_span;

    // The reference sum gets one extra bit so the midpoint is exact even
    // when both codes are near full scale; dropping bit 0 halves it.
    assign w_refSum   = {1'b0, i_supplyVol} + {1'b0, i_minVol};
    assign o_bodValue = w_refSum[DATA_W:1];

    // An inverted reference pair (nominal below minimum) yields a zero slew
    // limit, so any drop at all counts as fast.
    assign w_span      = i_supplyVol - i_minVol;
    assign o_rateLimit = (i_supplyVol >= i_minVol) ? (w_span >> RATE_SHIFT) : '0;

    // Equality with the threshold is deliberately not "below".
    assign o_below = (i_adc < o_bodValue);

`ifdef BOD_HYST_EN
    logic [DATA_W:0]   w_hystSum;
    logic [DATA_W-1:0] w_hystThresh;

    // The release level saturates at the top code, so near full scale the
    // alarms only clear once the ADC reports its maximum value.
    assign w_hystSum    = {1'b0, o_bodValue} + (DATA_W+1)'(HYST);
    assign w_hystThresh = w_hystSum[DATA_W] ? '1 : w_hystSum[DATA_W-1:0];
    assign o_clearOk    = (i_adc >= w_hystThresh);
`else
    assign o_clearOk = !o_below;
`endif

endmodule : bod_comparator

// File: rtl/bod_rate_monitor.sv
// ----------------------------------------------------------------------------
// bod_rate_monitor
// Brown-out detector for an ADC-sampled supply rail. Flags samples below a
// threshold derived from the nominal and minimum supply codes, and raises a
// brown-out only when the rail is below threshold and also falling faster
// than the allowed slew per sample.
// Ports:
//   clk         in   1       rising-edge clock
//   rst_n       in   1       synchronous active-low reset
//   adc_in      in   DATA_W  rail sample, one per cycle
//   supply_vol  in   DATA_W  nominal supply code (quasi-static)
//   min_vol     in   DATA_W  minimum allowed supply code (quasi-static)
//   bod_flag    out  1       registered: rail below threshold
//   brownout    out  1       registered: below threshold with a fast drop
// Macro BOD_HYST_EN: adds a HYST-LSB release band above the threshold.
// ----------------------------------------------------------------------------
module bod_rate_monitor
    import bod_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int HYST   = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] adc_in,
    input  logic [DATA_W-1:0] supply_vol,
    input  logic [DATA_W-1:0] min_vol,
    output logic              bod_flag,
    output logic              brownout
);

    logic [DATA_W-1:0] w_bodValue;
    logic [DATA_W-1:0] w_rateLimit;
    logic              w_below;
    logic              w_clearOk;
    logic [DATA_W-1:0] w_drop;
    logic              w_fastDrop;

    logic [DATA_W-1:0] r_prevAdc;
    logic              r_prevValid;
    logic              r_bodFlag;
    logic              r_brownout;

    bod_comparator #(
        .DATA_W (DATA_W),
        .HYST   (HYST)
    ) u_comparator (
        .i_adc       (adc_in),
        .i_supplyVol (supply_vol),
        .i_minVol    (min_vol),
        .o_bodValue  (w_bodValue),
        .o_rateLimit (w_rateLimit),
        .o_below     (w_below),
        .o_clearOk   (w_clearOk)
    );

    // Only a falling sample counts as a drop, and only once a previous
    // sample exists; this keeps the first post-reset sample from tripping.
    assign w_drop     = (r_prevValid && (adc_in < r_prevAdc)) ? (r_prevAdc - adc_in) : '0;
    assign w_fastDrop = (w_drop > w_rateLimit);

    // Sample history plus the two alarm registers. Both alarms set on their
    // own condition, release only when the rail is clearly back up, and
    // otherwise hold, which makes a tripped brown-out sticky while the rail
    // remains low even if the slew then eases off.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_prevAdc   <= '0;
            r_prevValid <= 1'b0;
            r_bodFlag   <= 1'b0;
            r_brownout  <= 1'b0;
        end else begin
            r_prevAdc   <= adc_in;
            r_prevValid <= 1'b1;

            if (w_below) begin
                r_bodFlag <= 1'b1;
            end else if (w_clearOk) begin
                r_bodFlag <= 1'b0;
            end

            if (w_below && w_fastDrop) begin
                r_brownout <= 1'b1;
            end else if (w_clearOk) begin
                r_brownout <= 1'b0;
            end
        end
    end

    assign bod_flag = r_bodFlag;
    assign brownout = r_brownout;

endmodule : bod_rate_monitor

// File: tb/tb_bod_rate_monitor.sv
// ----------------------------------------------------------------------------
// tb_bod_rate_monitor
// Self-checking bench for bod_rate_monitor. A behavioural model written from
// the plain threshold / slew rules tracks expected outputs; directed tests
// also compare against fixed expected values. Honours BOD_HYST_EN.
// ----------------------------------------------------------------------------
module tb_bod_rate_monitor;

    localparam int DW   = 8;
    localparam int HYST = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [DW-1:0] adc_in = '0;
    logic [DW-1:0] supply_vol = 8'd200;
    logic [DW-1:0] min_vol = 8'd100;
    logic          bod_flag;
    logic          brownout;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int  mPrev = 0;
    bit  mValid = 0;
    bit  mFlag = 0;
    bit  mBrown = 0;

    bod_rate_monitor #(
        .DATA_W (DW),
        .HYST   (HYST)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .adc_in     (adc_in),
        .supply_vol (supply_vol),
        .min_vol    (min_vol),
        .bod_flag   (bod_flag),
        .brownout   (brownout)
    );

    always #5 clk = ~clk;

    // Advance the reference model by one clock edge using the rules as
    // arithmetic on plain integers.
    task automatic modelStep(input int adc, input bit rstn);
        int sv, mv, thr, rate, drop, rel;
        bit below, clearOk, nFlag, nBrown;
        if (!rstn) begin
            mPrev = 0; mValid = 0; mFlag = 0; mBrown = 0;
        end else begin
            sv    = int'(supply_vol);
            mv    = int'(min_vol);
            thr   = (sv + mv) / 2;
            rate  = (sv >= mv) ? (sv - mv) / 8 : 0;
            below = (adc < thr);
            drop  = (mValid && adc < mPrev) ? (mPrev - adc) : 0;
`ifdef BOD_HYST_EN
            rel     = (thr + HYST > 255) ? 255 : thr + HYST;
            clearOk = (adc >= rel);
`else
            rel     = thr;
            clearOk = (adc >= rel);
`endif
            nFlag  = below ? 1'b1 : (clearOk ? 1'b0 : mFlag);
            nBrown = (below && drop > rate) ? 1'b1 : (clearOk ? 1'b0 : mBrown);
            mFlag  = nFlag;
            mBrown = nBrown;
            mPrev  = adc;
            mValid = 1'b1;
        end
    endtask

    // Drive one sample away from the active edge, clock it in, update the
    // model at the edge, then settle so outputs can be sampled safely.
    task automatic applyStimulus(input int adc, input bit rstn);
        @(negedge clk);
        adc_in = adc[DW-1:0];
        rst_n  = rstn;
        @(posedge clk);
        modelStep(adc, rstn);
        #1;
    endtask

    task automatic setRails(input int sv, input int mv);
        supply_vol = sv[DW-1:0];
        min_vol    = mv[DW-1:0];
    endtask

    task automatic test_reset();
        setRails(200, 100);
        applyStimulus(0, 1'b0);
        applyStimulus(0, 1'b0);
        checks++;
        if (bod_flag !== 1'b0 || brownout !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_outputs flag=%b brown=%b expected 0 0", bod_flag, brownout);
        end
        applyStimulus(0, 1'b1);
        checks++;
        if (bod_flag !== 1'b1 || brownout !== 1'b0) begin
            errors++;
            $display("[TB] FAIL first_sample_no_trip flag=%b brown=%b expected 1 0", bod_flag, brownout);
        end
    endtask

    task automatic test_fast_drop();
        int seq [3] = '{200, 200, 140};
        bit expF [3] = '{0, 0, 1};
        bit expB [3] = '{0, 0, 1};
        setRails(200, 100);
        applyStimulus(0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(seq[i], 1'b1);
            checks++;
            if (bod_flag !== expF[i] || brownout !== expB[i] || bod_flag !== mFlag || brownout !== mBrown) begin
                errors++;
                $display("[TB] FAIL fast_drop[%0d] flag=%b brown=%b expected %b %b", i, bod_flag, brownout, expF[i], expB[i]);
            end
        end
    endtask

    task automatic test_slow_drop();
        int seq [5] = '{160, 155, 150, 145, 140};
        bit expF [5] = '{0, 0, 0, 1, 1};
        int bnd [4] = '{149, 137, 124, 0};
        bit bndB [3] = '{0, 0, 1};
        setRails(200, 100);
        applyStimulus(0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(seq[i], 1'b1);
            checks++;
            if (bod_flag !== expF[i] || brownout !== 1'b0) begin
                errors++;
                $display("[TB] FAIL slow_drop[%0d] flag=%b brown=%b expected %b 0", i, bod_flag, brownout, expF[i]);
            end
        end
        // Drop equal to the limit landing exactly on the threshold
        applyStimulus(0, 1'b0);
        applyStimulus(162, 1'b1);
        applyStimulus(150, 1'b1);
        checks++;
        if (bod_flag !== 1'b0 || brownout !== 1'b0) begin
            errors++;
            $display("[TB] FAIL boundary_162_150 flag=%b brown=%b expected 0 0", bod_flag, brownout);
        end
        // Below threshold: drop of 12 must not trip, drop of 13 must
        applyStimulus(0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(bnd[i], 1'b1);
            checks++;
            if (brownout !== bndB[i] || bod_flag !== 1'b1) begin
                errors++;
                $display("[TB] FAIL rate_equal_limit[%0d] flag=%b brown=%b expected 1 %b", i, bod_flag, brownout, bndB[i]);
            end
        end
    endtask

    task automatic test_release();
        int seq [5] = '{140, 145, 150, 153, 154};
`ifdef BOD_HYST_EN
        bit expB [5] = '{1, 1, 1, 1, 0};
`else
        bit expB [5] = '{1, 1, 0, 0, 0};
`endif
        setRails(200, 100);
        applyStimulus(0, 1'b0);
        applyStimulus(200, 1'b1);
        applyStimulus(140, 1'b1);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(seq[i], 1'b1);
            checks++;
            if (brownout !== expB[i] || bod_flag !== expB[i]) begin
                errors++;
                $display("[TB] FAIL release[%0d] adc=%0d flag=%b brown=%b expected %b %b", i, seq[i], bod_flag, brownout, expB[i], expB[i]);
            end
        end
    endtask

    task automatic test_reset_mid_event();
        setRails(200, 100);
        applyStimulus(0, 1'b0);
        applyStimulus(200, 1'b1);
        applyStimulus(140, 1'b1);
        applyStimulus(140, 1'b0);
        checks++;
        if (bod_flag !== 1'b0 || brownout !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_mid_event flag=%b brown=%b expected 0 0", bod_flag, brownout);
        end
        applyStimulus(100, 1'b1);
        checks++;
        if (bod_flag !== 1'b1 || brownout !== 1'b0) begin
            errors++;
            $display("[TB] FAIL post_reset_sample flag=%b brown=%b expected 1 0", bod_flag, brownout);
        end
    endtask

    task automatic test_inverted_rails();
        setRails(50, 100);
        applyStimulus(0, 1'b0);
        applyStimulus(80, 1'b1);
        checks++;
        if (bod_flag !== 1'b0 || brownout !== 1'b0) begin
            errors++;
            $display("[TB] FAIL inverted_80 flag=%b brown=%b expected 0 0", bod_flag, brownout);
        end
        applyStimulus(74, 1'b1);
        checks++;
        if (bod_flag !== 1'b1 || brownout !== 1'b1) begin
            errors++;
            $display("[TB] FAIL inverted_74 flag=%b brown=%b expected 1 1", bod_flag, brownout);
        end
    endtask

    task automatic test_random();
        int railSets [5][2] = '{'{200, 100}, '{255, 250}, '{50, 100}, '{255, 255}, '{120, 20}};
        int sel, thr, adc;
        applyStimulus(0, 1'b0);
        for (int n = 0; n < 600; n++) begin
            if (n % 60 == 0) begin
                sel = int'($urandom_range(0, 4));
                setRails(railSets[sel][0], railSets[sel][1]);
            end
            thr = (int'(supply_vol) + int'(min_vol)) / 2;
            if ($urandom_range(0, 3) == 0) begin
                adc = int'($urandom_range(0, 255));
            end else begin
                adc = thr + int'($urandom_range(0, 40)) - 20;
                if (adc < 0) adc = 0;
                if (adc > 255) adc = 255;
            end
            applyStimulus(adc, ($urandom_range(0, 31) != 0));
            checks++;
            if (bod_flag !== mFlag || brownout !== mBrown) begin
                errors++;
                $display("[TB] FAIL random[%0d] adc=%0d sv=%0d mv=%0d flag=%b brown=%b expected %b %b",
                         n, adc, supply_vol, min_vol, bod_flag, brownout, mFlag, mBrown);
            end
        end
    endtask

    initial begin
        test_reset();
        test_fast_drop();
        test_slow_drop();
        test_release();
        test_reset_mid_event();
        test_inverted_rails();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_bod_rate_monitor
